// File: rtl/i4002_ram_dump_if.sv
// Byte-stream link from the RAM dump engine to its sink (UART TX or analyzer FIFO).
// A byte moves on every clock where out_valid and out_ready are both high.
interface i4002_ram_dump_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/i4002_ram_dump.sv
// Debug readout of one i4002 through its read-only second port.
// Each register becomes one ASCII-hex text line with a valid/ready handshake.
module i4002_ram_dump #(
  parameter bit          INCLUDE_STATUS = 1'b1,
  parameter int unsigned REG_COUNT      = 4
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        ram_addr,
  input  logic [3:0]        ram0_data,
  input  logic [3:0]        ram1_data,
  input  logic [3:0]        ram2_data,
  input  logic [3:0]        ram3_data,
  i4002_ram_dump_if.master  out_if
);

  // state   | meaning
  // IDLE    | waiting for start
  // HDR     | 'R', register digit, space (hdr_q selects which)
  // FETCH   | ram_addr stable, capture nibble
  // EMIT    | offer hex char of captured nibble
  // SEP     | space between data and status chars
  // CR / LF | line terminator
  // DONE    | one-cycle done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_SEP   = 3'd4;
  localparam logic [2:0] S_CR    = 3'd5;
  localparam logic [2:0] S_LF    = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] LAST_REG  = 2'(REG_COUNT - 1);
  localparam logic [4:0] LAST_CHAR = INCLUDE_STATUS ? 5'd19 : 5'd15;

  logic [2:0] state_q, state_d;
  logic [1:0] reg_q, reg_d;
  logic [1:0] hdr_q, hdr_d;
  logic [4:0] addr_q, addr_d;
  logic [3:0] nib_q, nib_d;
  logic [3:0] ram_nib;
  logic [7:0] byte_c;
  logic       valid_c;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    case (reg_q)
      2'd0:    ram_nib = ram0_data;
      2'd1:    ram_nib = ram1_data;
      2'd2:    ram_nib = ram2_data;
      default: ram_nib = ram3_data;
    endcase
  end

  // addr_q doubles as the character index within the line
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    nib_d   = nib_q;
    valid_c = 1'b0;
    byte_c  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          reg_d   = 2'd0;
          hdr_d   = 2'd0;
        end
      end
      S_HDR: begin
        valid_c = 1'b1;
        case (hdr_q)
          2'd0:    byte_c = 8'h52;
          2'd1:    byte_c = 8'h30 + {6'h00, reg_q};
          default: byte_c = 8'h20;
        endcase
        if (out_if.out_ready) begin
          if (hdr_q == 2'd2) begin
            state_d = S_FETCH;
            hdr_d   = 2'd0;
            addr_d  = 5'd0;
          end else begin
            hdr_d = hdr_q + 2'd1;
          end
        end
      end
      S_FETCH: begin
        nib_d   = ram_nib;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        valid_c = 1'b1;
        byte_c  = hex_ascii(nib_q);
        if (out_if.out_ready) begin
          if (addr_q == LAST_CHAR) begin
            state_d = S_CR;
          end else if (INCLUDE_STATUS && addr_q == 5'd15) begin
            state_d = S_SEP;
          end else begin
            state_d = S_FETCH;
            addr_d  = addr_q + 5'd1;
          end
        end
      end
      S_SEP: begin
        valid_c = 1'b1;
        byte_c  = 8'h20;
        if (out_if.out_ready) begin
          state_d = S_FETCH;
          addr_d  = 5'd16;
        end
      end
      S_CR: begin
        valid_c = 1'b1;
        byte_c  = 8'h0D;
        if (out_if.out_ready) state_d = S_LF;
      end
      S_LF: begin
        valid_c = 1'b1;
        byte_c  = 8'h0A;
        if (out_if.out_ready) begin
          if (reg_q == LAST_REG) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HDR;
            reg_d   = reg_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      reg_q   <= 2'd0;
      hdr_q   <= 2'd0;
      addr_q  <= 5'd0;
      nib_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      nib_q   <= nib_d;
    end
  end

  assign out_if.out_data  = byte_c;
  assign out_if.out_valid = valid_c;
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done             = (state_q == S_DONE);
  assign ram_addr         = addr_q;

endmodule

// File: tb/tb_i4002_ram_dump.sv
// Bench for i4002_ram_dump: two instances (defaults, and no-status/2 regs)
// checked against a string-building model of the dump text.
module tb_i4002_ram_dump;

  logic       sysclk;
  logic       reset_n;
  logic       start_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [4:0] addr_s  [2];
  logic [3:0] rdat    [2][4];
  logic [3:0] mem     [4][20];

  logic       vld [2];
  logic [7:0] dat [2];
  logic       rdy [2];
  bit         rand_rdy;

  i4002_ram_dump_if ifa ();
  i4002_ram_dump_if ifb ();

  assign vld[0] = ifa.out_valid;
  assign dat[0] = ifa.out_data;
  assign ifa.out_ready = rdy[0];
  assign vld[1] = ifb.out_valid;
  assign dat[1] = ifb.out_data;
  assign ifb.out_ready = rdy[1];

  i4002_ram_dump #(.INCLUDE_STATUS(1'b1), .REG_COUNT(4)) u_dut0 (
    .sysclk(sysclk), .reset_n(reset_n), .start(start_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .ram_addr(addr_s[0]),
    .ram0_data(rdat[0][0]), .ram1_data(rdat[0][1]),
    .ram2_data(rdat[0][2]), .ram3_data(rdat[0][3]),
    .out_if(ifa)
  );

  i4002_ram_dump #(.INCLUDE_STATUS(1'b0), .REG_COUNT(2)) u_dut1 (
    .sysclk(sysclk), .reset_n(reset_n), .start(start_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .ram_addr(addr_s[1]),
    .ram0_data(rdat[1][0]), .ram1_data(rdat[1][1]),
    .ram2_data(rdat[1][2]), .ram3_data(rdat[1][3]),
    .out_if(ifb)
  );

  // combinational second-port read, as the i4002 provides
  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 4; r++)
        rdat[d][r] = (addr_s[d] < 5'd20) ? mem[r][addr_s[d]] : 4'h0;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial forever begin
    @(posedge sysclk);
    cyc++;
  end

  initial begin
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    forever begin
      @(posedge sysclk);
      #1;
      for (int d = 0; d < 2; d++)
        rdy[d] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: collects transferred bytes, checks stall stability, counts done pulses.
  logic [7:0] got_mem   [2][256];
  int         got_n     [2];
  int         done_cnt  [2];
  int         first_cyc [2];
  bit         stall_q   [2];
  logic [7:0] stall_dat [2];
  int         addr_over = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      got_n[d] = 0; done_cnt[d] = 0; first_cyc[d] = -1;
      stall_q[d] = 1'b0; stall_dat[d] = 8'h00;
    end
    forever begin
      @(negedge sysclk);
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) begin
          stall_q[d] = 1'b0;
        end else begin
          if (stall_q[d]) begin
            check_eq("stall_valid", {31'b0, vld[d]}, 32'd1);
            check_eq("stall_data", {24'b0, dat[d]}, {24'b0, stall_dat[d]});
          end
          if (vld[d] && rdy[d] && got_n[d] < 256) begin
            got_mem[d][got_n[d]] = dat[d];
            got_n[d]++;
          end
          if (vld[d] && first_cyc[d] < 0) first_cyc[d] = cyc;
          if (done_s[d]) done_cnt[d]++;
          stall_q[d]   = vld[d] && !rdy[d];
          stall_dat[d] = dat[d];
        end
      end
      if (addr_s[1] > 5'd15) addr_over++;
    end
  end

  // Reference model: the dump text built directly from the memory image.
  logic [7:0] exp_mem [256];

  task automatic build_exp(input int d, output int n, output int n_hex);
    string hx;
    int    regs;
    bit    stat;
    hx    = "0123456789ABCDEF";
    regs  = (d == 0) ? 4 : 2;
    stat  = (d == 0);
    n     = 0;
    n_hex = 0;
    for (int r = 0; r < regs; r++) begin
      exp_mem[n++] = "R";
      exp_mem[n++] = 8'(48 + r);
      exp_mem[n++] = " ";
      for (int c = 0; c < 16; c++) begin
        exp_mem[n++] = hx[mem[r][c]];
        n_hex++;
      end
      if (stat) begin
        exp_mem[n++] = " ";
        for (int c = 16; c < 20; c++) begin
          exp_mem[n++] = hx[mem[r][c]];
          n_hex++;
        end
      end
      exp_mem[n++] = 8'h0D;
      exp_mem[n++] = 8'h0A;
    end
  endtask

  task automatic do_dump(input int d, input bit rnd, input bit pulses, input bit timed);
    int n_exp, n_hex, c0, budget;
    bit p10;
    build_exp(d, n_exp, n_hex);
    rand_rdy     = rnd;
    got_n[d]     = 0;
    done_cnt[d]  = 0;
    first_cyc[d] = -1;
    p10          = 1'b0;
    @(posedge sysclk); #1;
    start_s[d] = 1'b1;
    c0 = cyc;
    @(posedge sysclk); #1;
    start_s[d] = 1'b0;
    budget = 0;
    while (!done_s[d] && budget < 4000) begin
      if (pulses && !p10 && got_n[d] >= 10) begin
        start_s[d] = 1'b1;
        p10 = 1'b1;
      end else begin
        start_s[d] = 1'b0;
      end
      @(posedge sysclk); #1;
      budget++;
    end
    start_s[d] = 1'b0;
    check_eq("done_seen", {31'b0, done_s[d]}, 32'd1);
    if (timed) begin
      check_eq("lat_first_R", first_cyc[d] - c0, 32'd1);
      check_eq("lat_done", cyc - c0, 1 + n_exp + n_hex);
    end
    if (pulses) begin
      start_s[d] = 1'b1;
      @(posedge sysclk); #1;
      start_s[d] = 1'b0;
    end
    repeat (30) @(posedge sysclk);
    #1;
    check_eq("done_count", done_cnt[d], 32'd1);
    check_eq("byte_count", got_n[d], n_exp);
    check_eq("busy_idle", {31'b0, busy_s[d]}, 32'd0);
    for (int i = 0; i < n_exp; i++)
      check_eq($sformatf("byte%0d_dut%0d", i, d), {24'b0, got_mem[d][i]}, {24'b0, exp_mem[i]});
  endtask

  task automatic check_reset_outputs(input int d);
    check_eq("rst_busy", {31'b0, busy_s[d]}, 32'd0);
    check_eq("rst_done", {31'b0, done_s[d]}, 32'd0);
    check_eq("rst_valid", {31'b0, vld[d]}, 32'd0);
    check_eq("rst_data", {24'b0, dat[d]}, 32'd0);
    check_eq("rst_addr", {27'b0, addr_s[d]}, 32'd0);
  endtask

  initial begin
    int budget;
    reset_n    = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    rand_rdy   = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 20; c++)
        mem[r][c] = 4'($urandom_range(0, 15));
    for (int c = 0; c < 16; c++) mem[0][c] = 4'(c);
    mem[0][16] = 4'h5; mem[0][17] = 4'hA; mem[0][18] = 4'h0; mem[0][19] = 4'hF;

    repeat (3) @(posedge sysclk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset_n = 1'b1;

    // directed image, sink always ready
    do_dump(0, 1'b0, 1'b0, 1'b1);

    // random image, random backpressure, stray start pulses
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 20; c++)
        mem[r][c] = 4'($urandom_range(0, 15));
    do_dump(0, 1'b1, 1'b1, 1'b0);

    // reset in the middle of a dump
    rand_rdy = 1'b0;
    got_n[0] = 0;
    @(posedge sysclk); #1;
    start_s[0] = 1'b1;
    @(posedge sysclk); #1;
    start_s[0] = 1'b0;
    budget = 0;
    while (got_n[0] < 40 && budget < 1000) begin
      @(posedge sysclk); #1;
      budget++;
    end
    check_eq("reach_byte40", {31'b0, got_n[0] >= 40}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(0);
    repeat (2) @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    do_dump(0, 1'b0, 1'b0, 1'b1);

    // reduced configuration
    do_dump(1, 1'b0, 1'b0, 1'b1);
    do_dump(1, 1'b1, 1'b0, 1'b0);
    check_eq("addr_max15", addr_over, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
